// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and data-RAM bus bundle for lsu_mem_ctrl
//
// Purpose: groups the core-side request/response handshake and the word-wide
// synchronous RAM port into one bundle.
// Modports:
//   master - core side: drives req_*, observes req_ready and rsp_*
//   slave  - controller side: accepts req_*, drives rsp_* and the RAM port
//   mem    - RAM side: observes mem_we/mem_addr/mem_wdata, returns mem_rdata
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport mem (
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - byte/half/word load-store initiator for a word-wide synchronous RAM
//
// Purpose: accepts one load or store at a time, performs sub-word stores as
// read-modify-write, extracts and extends load lanes, and flags misaligned or
// out-of-range accesses without touching memory.
// Ports:
//   clk   - rising-edge clock shared with the RAM
//   rst_n - synchronous active-low reset
//   bus   - lsu_mem_ctrl_if.slave: req_* handshake in, rsp_* completion out,
//           mem_we/mem_addr/mem_wdata/mem_rdata RAM port
module lsu_mem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic        req_err;
    logic [4:0]  sh_amt;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    // Anything above the RAM's byte range is an error; a shift keeps this
    // legal for every MEM_ADDR_WIDTH, including ones that leave no spare bits.
    assign req_err = (bus.req_size == 2'b11)
                  || (bus.req_size == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                  || ((bus.req_addr >> (MEM_ADDR_WIDTH + 2)) != 32'd0);

    // Lane logic works on the latched byte offset; alignment is already
    // guaranteed for halves, so a plain byte shift serves both sizes.
    assign sh_amt = {off_q, 3'b000};
    assign lane   = bus.mem_rdata >> sh_amt;

    always_comb begin
        load_val = bus.mem_rdata;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_val = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_val = bus.mem_rdata;
        endcase
    end

    assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh_amt;
    assign merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << sh_amt) & lane_mask);

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        off_d     = off_q;
        size_d    = size_q;
        we_d      = we_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    waddr_d = bus.req_addr[31:2];
                    off_d   = bus.req_addr[1:0];
                    size_d  = bus.req_size;
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'd0;
                    err_d   = req_err;
                    if (req_err)
                        state_d = RSP;
                    else if (bus.req_we && bus.req_size == 2'b10)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                // The speculative read issued at accept returns here.
                if (we_q) begin
                    wdata_d = merged;
                    state_d = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RSP;
                end
            end
            WR:      state_d = RSP;
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RSP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            off_q       <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Gating with rst_n blocks a write that was in flight when reset hit.
    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.mem_we    = rst_n && (state_q == WR);
    assign bus.mem_addr  = (state_q == IDLE) ? {bus.req_addr[31:2], 2'b00} : {waddr_q, 2'b00};
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl with a behavioural RAM and reference model
module tb_lsu_mem_ctrl;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    bit   cmp_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM: read data appears the cycle after the address.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[AW+1:2]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[AW+1:2]];
    end

    // Reference model state and cycle-indexed expectations.
    logic [31:0] model_mem [int];
    bit          busy      [int];
    bit          exp_rv    [int];
    logic [31:0] exp_rdata [int];
    logic        exp_err   [int];
    logic [31:0] exp_waddr [int];
    logic [31:0] exp_wdata [int];

    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_wdata = '0;
    int          rsp_cnt = 0;
    int          we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_load(logic [31:0] word, logic [1:0] size, logic uns, logic [1:0] off);
        int n = 1 << size;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] word, logic [1:0] size, logic [1:0] off, logic [31:0] wd);
        int n = 1 << size;
        logic [31:0] w = word;
        for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    function automatic bit m_err(logic [1:0] size, logic [31:0] addr);
        return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00) || (64'(addr) >= 64'(4) * (64'(1) << AW));
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(rst_n && !busy.exists(cyc)));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv.exists(cyc)));
            if (exp_rv.exists(cyc)) begin
                chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err[cyc]));
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata[cyc]);
            end
            chk("mem_we", 32'(bus.mem_we), 32'(exp_waddr.exists(cyc)));
            if (exp_waddr.exists(cyc)) begin
                chk("mem_addr", bus.mem_addr, exp_waddr[cyc]);
                chk("mem_wdata", bus.mem_wdata, exp_wdata[cyc]);
            end
            if (bus.rsp_valid) begin
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                rsp_cnt++;
            end
            if (bus.mem_we) begin
                last_wdata = bus.mem_wdata;
                we_cnt++;
            end
        end
    end

    task automatic scramble();
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int p, lat, wa;
        logic [31:0] old;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        p   = cyc;
        wa  = int'(addr[31:2]);
        old = model_mem.exists(wa) ? model_mem[wa] : 32'd0;
        if (m_err(size, addr)) begin
            lat = 1;
            exp_err[p+1] = 1'b1; exp_rdata[p+1] = 32'd0;
        end else if (!we) begin
            lat = 2;
            exp_err[p+2] = 1'b0; exp_rdata[p+2] = m_load(old, size, uns, addr[1:0]);
        end else if (size == 2'b10) begin
            lat = 2;
            exp_waddr[p+1] = {addr[31:2], 2'b00}; exp_wdata[p+1] = wd;
            model_mem[wa] = wd;
            exp_err[p+2] = 1'b0; exp_rdata[p+2] = 32'd0;
        end else begin
            lat = 3;
            exp_waddr[p+2] = {addr[31:2], 2'b00};
            exp_wdata[p+2] = m_store(old, size, addr[1:0], wd);
            model_mem[wa] = exp_wdata[p+2];
            exp_err[p+3] = 1'b0; exp_rdata[p+3] = 32'd0;
        end
        exp_rv[p+lat] = 1'b1;
        for (int i = 1; i <= lat; i++) busy[p+i] = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        repeat (lat - 1) @(posedge clk);
        @(negedge clk); #1;
    endtask

    // sh at 0x100 with reset asserted in cycle k (1 = RD, 2 = WR): no write, no response.
    task automatic do_rst_req(input int k);
        int p;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h100; bus.req_wdata = 32'h0000_5555;
        p = cyc;
        for (int i = 1; i <= k; i++) busy[p+i] = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        if (k == 2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'd0;
        ram[32'h40] = 32'h8899_AABB;
        model_mem[32'h40] = 32'h8899_AABB;
        bus.req_valid = 1'b0;
        scramble();

        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        do_req(1'b0, 2'b00, 1'b0, 32'h102, 32'd0);
        chk("lit_lb", last_rdata, 32'hFFFF_FF99);
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0);
        chk("lit_lhu", last_rdata, 32'h0000_8899);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'd0);
        chk("lit_lh", last_rdata, 32'hFFFF_8899);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        chk("lit_lw", last_rdata, 32'h8899_AABB);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
        chk("lit_lbu", last_rdata, 32'h0000_0088);
        chk("lit_no_we_yet", 32'(we_cnt), 32'd0);

        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_5677);
        chk("lit_sb_wdata", last_wdata, 32'h8899_77BB);
        chk("lit_sb_rdata", last_rdata, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        chk("lit_lw_after_sb", last_rdata, 32'h8899_77BB);

        do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
        chk("lit_lw_after_sw", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFF_1357);
        do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'd0);
        chk("lit_lw_after_sh", last_rdata, 32'h1357_BEEF);

        do_req(1'b1, 2'b10, 1'b0, 32'h3FFFC, 32'hCAFE_F00D);
        do_req(1'b0, 2'b01, 1'b0, 32'h3FFFE, 32'd0);
        chk("lit_top_lh", last_rdata, 32'hFFFF_CAFE);

        rc = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'd0);
        chk("lit_err_lw", 32'(last_err), 32'd1);
        do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h1111_1111);
        chk("lit_err_sh", 32'(last_err), 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'd0);
        chk("lit_err_size", 32'(last_err), 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 32'h0004_0000, 32'h2222_2222);
        chk("lit_err_range", 32'(last_err), 32'd1);
        chk("err_no_we", 32'(we_cnt), 32'(rc));

        rc = rsp_cnt;
        do_rst_req(1);
        do_rst_req(2);
        chk("rst_no_rsp", 32'(rsp_cnt), 32'(rc));
        chk("rst_ram_kept", ram[32'h40], 32'h8899_77BB);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        chk("lit_lw_after_rst", last_rdata, 32'h8899_77BB);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
